// File: rtl/bus_arbiter_if.sv
// Bus arbiter signal bundle: master-side request/select/split inputs and the
// grant outputs. "master" is the requesting side, "slave" is the arbiter side.
interface bus_arbiter_if #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int MW = $clog2(NM)
);
  logic [NM-1:0] M_REQ;
  logic [NM-1:0] M_GNT;
  logic [NS-1:0] S_SEL;
  logic [NS-1:0] S_SPLIT;
  logic [MW-1:0] B_MSEL;
  logic          B_GNT_VALID;
  logic [NM-1:0] SPLIT_PEND;

  modport master (
    output M_REQ, S_SEL, S_SPLIT,
    input  M_GNT, B_MSEL, B_GNT_VALID, SPLIT_PEND
  );

  modport slave (
    input  M_REQ, S_SEL, S_SPLIT,
    output M_GNT, B_MSEL, B_GNT_VALID, SPLIT_PEND
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle turnaround between owners and
// split-transaction parking with priority re-grant of released masters.
module bus_arbiter #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int MW = $clog2(NM)
) (
  input  logic           CLK,
  input  logic           RSTN,
  bus_arbiter_if.slave   bus
);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [MW-1:0] RR_RESET = MW'(NM - 1);
  localparam logic [NM-1:0] ONE_HOT0 = NM'(1);

  typedef enum logic [1:0] {IDLE, GRANTED, HANDOVER} state_t;

  state_t        state_q;
  logic [NM-1:0] gnt_q;
  logic [NM-1:0] pend_q;
  logic [MW-1:0] msel_q;
  logic [MW-1:0] rr_q;
  logic          valid_q;
  logic [SW-1:0] splitSlave_q [NM];

  logic [NM-1:0] released;
  logic [NM-1:0] normal;
  logic [NS-1:0] splitHit;
  logic [SW-1:0] splitIdx;
  logic          selFound;
  logic          selReleased;
  logic [MW-1:0] selIdx;
  logic          ownerReq;

  assign splitHit = bus.S_SPLIT & bus.S_SEL;
  assign ownerReq = bus.M_REQ[msel_q];

  always_comb begin
    released = '0;
    normal   = '0;
    for (int m = 0; m < NM; m++) begin
      normal[m]   = bus.M_REQ[m] & ~pend_q[m];
      released[m] = bus.M_REQ[m] & pend_q[m] & ~bus.S_SPLIT[splitSlave_q[m]];
    end
  end

  always_comb begin
    splitIdx = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (splitHit[s]) splitIdx = SW'(s);
    end
  end

  // Descending loops so the last hit (lowest index / nearest after rr_q) wins.
  always_comb begin
    int idx;
    idx         = 0;
    selFound    = 1'b0;
    selReleased = 1'b0;
    selIdx      = '0;
    for (int m = NM - 1; m >= 0; m--) begin
      if (released[m]) begin
        selFound    = 1'b1;
        selReleased = 1'b1;
        selIdx      = MW'(m);
      end
    end
    if (!selFound) begin
      for (int k = NM; k >= 1; k--) begin
        idx = (int'(rr_q) + k) % NM;
        if (normal[idx]) begin
          selFound = 1'b1;
          selIdx   = MW'(idx);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      pend_q  <= '0;
      msel_q  <= '0;
      rr_q    <= RR_RESET;
      valid_q <= 1'b0;
      for (int m = 0; m < NM; m++) splitSlave_q[m] <= '0;
    end else begin
      // A parked master that drops its request abandons the split.
      for (int m = 0; m < NM; m++) begin
        if (!bus.M_REQ[m]) pend_q[m] <= 1'b0;
      end
      case (state_q)
        IDLE, HANDOVER: begin
          if (selFound) begin
            state_q <= GRANTED;
            gnt_q   <= ONE_HOT0 << selIdx;
            msel_q  <= selIdx;
            valid_q <= 1'b1;
            if (selReleased) pend_q[selIdx] <= 1'b0;
            else             rr_q <= selIdx;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANTED: begin
          if (!ownerReq) begin
            state_q <= HANDOVER;
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end else if (|splitHit) begin
            state_q              <= HANDOVER;
            gnt_q                <= '0;
            valid_q              <= 1'b0;
            pend_q[msel_q]       <= 1'b1;
            splitSlave_q[msel_q] <= splitIdx;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.M_GNT       = gnt_q;
  assign bus.B_MSEL      = msel_q;
  assign bus.B_GNT_VALID = valid_q;
  assign bus.SPLIT_PEND  = pend_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random traffic,
// checked against a behavioural ownership/round-robin/split model.
module tb_bus_arbiter;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int MW = $clog2(NM);

  typedef struct packed {
    logic [NM-1:0] gnt;
    logic [MW-1:0] msel;
    logic          valid;
    logic [NM-1:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;

  bus_arbiter_if #(.NM(NM), .NS(NS), .MW(MW)) bus ();

  bus_arbiter #(.NM(NM), .NS(NS), .MW(MW)) dut (
    .CLK  (clk),
    .RSTN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  // Reference model: who owns the bus, who is parked and on which slave.
  int owner;
  int lastSel;
  int rrPtr;
  bit pending [NM];
  int slaveOf [NM];

  task automatic modelReset();
    owner   = -1;
    lastSel = 0;
    rrPtr   = NM - 1;
    for (int m = 0; m < NM; m++) begin
      pending[m] = 1'b0;
      slaveOf[m] = 0;
    end
    expQ.delete();
  endtask

  task automatic modelStep(input logic [NM-1:0] req, input logic [NS-1:0] sel,
                           input logic [NS-1:0] split);
    int found;
    bit rel;
    logic [NS-1:0] hit;
    found = -1;
    rel   = 1'b0;
    hit   = split & sel;
    for (int m = 0; m < NM; m++) if (!req[m]) pending[m] = 1'b0;
    if (owner >= 0) begin
      if (!req[owner]) begin
        owner = -1;
      end else if (hit != '0) begin
        pending[owner] = 1'b1;
        for (int s = NS - 1; s >= 0; s--) if (hit[s]) slaveOf[owner] = s;
        owner = -1;
      end
    end else begin
      for (int m = 0; m < NM; m++)
        if (found < 0 && pending[m] && req[m] && !split[slaveOf[m]]) begin
          found = m;
          rel   = 1'b1;
        end
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (rrPtr + k) % NM;
        if (found < 0 && req[c] && !pending[c]) found = c;
      end
      if (found >= 0) begin
        owner   = found;
        lastSel = found;
        if (rel) pending[found] = 1'b0;
        else     rrPtr = found;
      end
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    e.gnt   = '0;
    e.pend  = '0;
    if (owner >= 0) e.gnt[owner] = 1'b1;
    e.msel  = MW'(lastSel);
    e.valid = (owner >= 0);
    for (int m = 0; m < NM; m++) e.pend[m] = pending[m];
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic applyStimulus(input logic [NM-1:0] req, input logic [NS-1:0] sel,
                               input logic [NS-1:0] split);
    @(negedge clk);
    bus.M_REQ   = req;
    bus.S_SEL   = sel;
    bus.S_SPLIT = split;
    modelStep(req, sel, split);
    expQ.push_back(modelOutputs());
  endtask

  task automatic checkField(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, got, want);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("gnt",   32'(bus.M_GNT),       32'(e.gnt));
    checkField("msel",  32'(bus.B_MSEL),      32'(e.msel));
    checkField("valid", 32'(bus.B_GNT_VALID), 32'(e.valid));
    checkField("pend",  32'(bus.SPLIT_PEND),  32'(e.pend));
  endtask

  always @(posedge clk) begin
    #1;
    cycle++;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Reset asserted mid-cycle must clear the outputs before any clock edge.
  task automatic asyncResetCheck(input string tag);
    @(posedge clk);
    #3;
    rstN        = 1'b0;
    bus.M_REQ   = '0;
    bus.S_SEL   = '0;
    bus.S_SPLIT = '0;
    #1;
    checkField({tag, "_gnt"},   32'(bus.M_GNT),       32'd0);
    checkField({tag, "_pend"},  32'(bus.SPLIT_PEND),  32'd0);
    checkField({tag, "_valid"}, 32'(bus.B_GNT_VALID), 32'd0);
    checkField({tag, "_msel"},  32'(bus.B_MSEL),      32'd0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [NM-1:0] reqR;
    logic [NS-1:0] selR;
    logic [NS-1:0] splitR;
    rstN        = 1'b0;
    bus.M_REQ   = '0;
    bus.S_SEL   = '0;
    bus.S_SPLIT = '0;
    modelReset();
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // Single master grant and release.
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);

    // Round-robin handover with one dead cycle.
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b10, 3'b001, 3'b000);
    applyStimulus(2'b10, 3'b001, 3'b000);
    applyStimulus(2'b10, 3'b001, 3'b000);
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);

    // Split park, no preemption on release, priority re-grant.
    applyStimulus(2'b01, 3'b010, 3'b000);
    applyStimulus(2'b01, 3'b010, 3'b000);
    applyStimulus(2'b11, 3'b010, 3'b010);
    applyStimulus(2'b11, 3'b001, 3'b010);
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b01, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);

    // Abort of a parked master.
    applyStimulus(2'b01, 3'b010, 3'b000);
    applyStimulus(2'b11, 3'b010, 3'b010);
    applyStimulus(2'b11, 3'b001, 3'b010);
    applyStimulus(2'b10, 3'b001, 3'b010);
    applyStimulus(2'b10, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);
    applyStimulus(2'b00, 3'b001, 3'b000);

    // Split from an unselected slave is ignored; release beats split.
    applyStimulus(2'b01, 3'b001, 3'b100);
    applyStimulus(2'b01, 3'b001, 3'b100);
    applyStimulus(2'b01, 3'b001, 3'b100);
    applyStimulus(2'b00, 3'b001, 3'b001);
    applyStimulus(2'b00, 3'b001, 3'b000);

    // Async reset with a grant active and a split pending.
    applyStimulus(2'b01, 3'b010, 3'b000);
    applyStimulus(2'b11, 3'b010, 3'b010);
    applyStimulus(2'b11, 3'b001, 3'b010);
    applyStimulus(2'b11, 3'b001, 3'b010);
    asyncResetCheck("rst1");
    applyStimulus(2'b11, 3'b001, 3'b000);
    applyStimulus(2'b11, 3'b001, 3'b000);

    reqR   = '0;
    selR   = 3'b001;
    splitR = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < NM; m++)
        if ($urandom_range(0, 7) == 0) reqR[m] = ~reqR[m];
      selR = '0;
      selR[$urandom_range(0, NS - 1)] = 1'b1;
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 3) == 0) splitR[s] = ~splitR[s];
      applyStimulus(reqR, selR, splitR);
      if (i == 1500) begin
        asyncResetCheck("rst2");
        reqR   = '0;
        splitR = '0;
      end
    end

    repeat (2) @(posedge clk);
    #2;
    checkField("drain", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
